// File: rtl/acumulador_pulsos.sv
// Two-button up/down accumulator: each raw button is synchronized and debounced,
// and an accepted press moves the 2-bit valor up or down (wrapping or saturating).
module acumulador_pulsos #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit SATURAR         = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       boton_inc,
  input  logic       boton_dec,
  input  logic       limpiar,
  output logic [1:0] valor,
  output logic       cambio,
  output logic       ocupado
);

  localparam logic [1:0] ESPERA        = 2'd0;
  localparam logic [1:0] CONFIRMA_ALTO = 2'd1;
  localparam logic [1:0] ACTIVO        = 2'd2;
  localparam logic [1:0] CONFIRMA_BAJO = 2'd3;

  localparam logic [15:0] CNT_FIN = 16'(DEBOUNCE_CYCLES);

  // Index 0 is the increment button, index 1 the decrement button.
  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  r_estado [2];
  logic [15:0] r_cnt    [2];
  logic [1:0]  r_valor;
  logic        r_cambio;

  logic [1:0]  w_estado_sig [2];
  logic [15:0] w_cnt_sig    [2];
  logic [15:0] w_cnt_mas    [2];
  logic [1:0]  w_press;
  logic [1:0]  w_valor_sig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {boton_dec, boton_inc};
      r_sync2 <= r_sync1;
    end
  end

  // A press is accepted only on the edge that confirms a stable high level.
  always_comb begin
    w_press = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_estado_sig[i] = r_estado[i];
      w_cnt_sig[i]    = r_cnt[i];
      w_cnt_mas[i]    = r_cnt[i] + 16'd1;
      case (r_estado[i])
        ESPERA: begin
          if (r_sync2[i]) begin
            w_estado_sig[i] = CONFIRMA_ALTO;
            w_cnt_sig[i]    = 16'd1;
          end
        end
        CONFIRMA_ALTO: begin
          if (!r_sync2[i]) begin
            w_estado_sig[i] = ESPERA;
            w_cnt_sig[i]    = 16'd0;
          end else if (w_cnt_mas[i] == CNT_FIN) begin
            w_estado_sig[i] = ACTIVO;
            w_cnt_sig[i]    = 16'd0;
            w_press[i]      = 1'b1;
          end else begin
            w_cnt_sig[i] = w_cnt_mas[i];
          end
        end
        ACTIVO: begin
          if (!r_sync2[i]) begin
            w_estado_sig[i] = CONFIRMA_BAJO;
            w_cnt_sig[i]    = 16'd1;
          end
        end
        CONFIRMA_BAJO: begin
          if (r_sync2[i]) begin
            w_estado_sig[i] = ACTIVO;
            w_cnt_sig[i]    = 16'd0;
          end else if (w_cnt_mas[i] == CNT_FIN) begin
            w_estado_sig[i] = ESPERA;
            w_cnt_sig[i]    = 16'd0;
          end else begin
            w_cnt_sig[i] = w_cnt_mas[i];
          end
        end
        default: begin
          w_estado_sig[i] = ESPERA;
          w_cnt_sig[i]    = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_estado[i] <= ESPERA;
        r_cnt[i]    <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_estado[i] <= w_estado_sig[i];
        r_cnt[i]    <= w_cnt_sig[i];
      end
    end
  end

  // Simultaneous inc and dec cancel; limpiar overrides both.
  always_comb begin
    w_valor_sig = r_valor;
    if (limpiar) begin
      w_valor_sig = 2'b00;
    end else if (w_press == 2'b01) begin
      if (!(SATURAR && (r_valor == 2'b11))) begin
        w_valor_sig = r_valor + 2'd1;
      end
    end else if (w_press == 2'b10) begin
      if (!(SATURAR && (r_valor == 2'b00))) begin
        w_valor_sig = r_valor - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valor  <= 2'b00;
      r_cambio <= 1'b0;
    end else begin
      r_valor  <= w_valor_sig;
      r_cambio <= (w_valor_sig != r_valor);
    end
  end

  assign valor   = r_valor;
  assign cambio  = r_cambio;
  assign ocupado = (r_estado[0] == CONFIRMA_ALTO) || (r_estado[0] == CONFIRMA_BAJO) ||
                   (r_estado[1] == CONFIRMA_ALTO) || (r_estado[1] == CONFIRMA_BAJO);

endmodule

// File: tb/tb_acumulador_pulsos.sv
// Bench for acumulador_pulsos: one wrapping and one saturating instance share stimulus
// and are compared each cycle against a run-length debounce model.
module tb_acumulador_pulsos;

  localparam int D = 4;

  typedef struct {
    bit       rstn;
    bit       inc;
    bit       dec;
    bit       clr;
    bit [1:0] expValor;
    bit       expCambio;
    bit       expOcup;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, boton_inc, boton_dec, limpiar;
  logic [1:0] valor0, valor1;
  logic       cambio0, cambio1, ocup0, ocup1;

  always #5 clk = ~clk;

  acumulador_pulsos #(.DEBOUNCE_CYCLES(D), .SATURAR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .boton_inc(boton_inc), .boton_dec(boton_dec),
    .limpiar(limpiar), .valor(valor0), .cambio(cambio0), .ocupado(ocup0)
  );

  acumulador_pulsos #(.DEBOUNCE_CYCLES(D), .SATURAR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .boton_inc(boton_inc), .boton_dec(boton_dec),
    .limpiar(limpiar), .valor(valor1), .cambio(cambio1), .ocupado(ocup1)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Model state: sampled-level pipeline, debounced level and run of disagreeing samples.
  bit       mSh1 [2];
  bit       mSh2 [2];
  bit       mLvl [2];
  int       mRun [2];
  bit [1:0] mVal [2];
  bit       mCambio [2];
  bit       mOcup;

  int pulses0, pulses1, ocupCount;
  vec_t tbl [18];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual %0d, required %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void modelStep(bit rstn, bit inc, bit dec, bit clr);
    bit raw [2];
    bit acc [2];
    bit s;
    int oldV, newV;
    raw[0] = inc;
    raw[1] = dec;
    if (!rstn) begin
      for (int b = 0; b < 2; b++) begin
        mSh1[b] = 0; mSh2[b] = 0; mLvl[b] = 0; mRun[b] = 0;
        mVal[b] = 2'd0; mCambio[b] = 0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        s = mSh2[b];
        mSh2[b] = mSh1[b];
        mSh1[b] = raw[b];
        acc[b] = 0;
        if (s != mLvl[b]) begin
          mRun[b]++;
          if (mRun[b] == D) begin
            mLvl[b] = s;
            mRun[b] = 0;
            acc[b]  = s;
          end
        end else begin
          mRun[b] = 0;
        end
      end
      for (int v = 0; v < 2; v++) begin
        oldV = int'(mVal[v]);
        newV = oldV;
        if (clr) newV = 0;
        else if (acc[0] && !acc[1]) newV = (v == 1 && oldV == 3) ? 3 : (oldV + 1) % 4;
        else if (acc[1] && !acc[0]) newV = (v == 1 && oldV == 0) ? 0 : (oldV + 3) % 4;
        mCambio[v] = (newV != oldV);
        mVal[v]    = 2'(newV);
      end
    end
    mOcup = (mRun[0] != 0) || (mRun[1] != 0);
  endfunction

  task automatic applyStimulus(input bit rstn, input bit inc, input bit dec, input bit clr);
    rst_n     = rstn;
    boton_inc = inc;
    boton_dec = dec;
    limpiar   = clr;
    @(posedge clk);
    modelStep(rstn, inc, dec, clr);
    @(negedge clk);
    checkOutput("model_valor_wrap", valor0, mVal[0]);
    checkOutput("model_valor_sat", valor1, mVal[1]);
    checkOutput("model_cambio_wrap", cambio0, mCambio[0]);
    checkOutput("model_cambio_sat", cambio1, mCambio[1]);
    checkOutput("model_ocupado_wrap", ocup0, mOcup);
    checkOutput("model_ocupado_sat", ocup1, mOcup);
    pulses0   += int'(cambio0);
    pulses1   += int'(cambio1);
    ocupCount += int'(ocup0);
  endtask

  task automatic pressBtn(input bit inc, input bit dec, input int hold, input int rel);
    for (int i = 0; i < hold; i++) applyStimulus(1'b1, inc, dec, 1'b0);
    for (int i = 0; i < rel; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic vec_t makeVec(bit r, bit i, bit d, bit c, bit [1:0] v, bit cb, bit o);
    vec_t e;
    e.rstn = r; e.inc = i; e.dec = d; e.clr = c;
    e.expValor = v; e.expCambio = cb; e.expOcup = o;
    return e;
  endfunction

  initial begin
    bit [1:0] exp0 [4];
    bit [1:0] exp1 [4];
    bit       pat [4];
    bit [1:0] base0;
    int       holdInc, holdDec;
    bit       lvlInc, lvlDec;

    rst_n = 1'b0; boton_inc = 1'b0; boton_dec = 1'b0; limpiar = 1'b0;
    pulses0 = 0; pulses1 = 0; ocupCount = 0;

    // Single held press: sampled at entry 1, accepted at entry 6, release debounced later.
    tbl[0]  = makeVec(0, 0, 0, 0, 2'd0, 0, 0);
    tbl[1]  = makeVec(1, 1, 0, 0, 2'd0, 0, 0);
    tbl[2]  = makeVec(1, 1, 0, 0, 2'd0, 0, 0);
    tbl[3]  = makeVec(1, 1, 0, 0, 2'd0, 0, 1);
    tbl[4]  = makeVec(1, 1, 0, 0, 2'd0, 0, 1);
    tbl[5]  = makeVec(1, 1, 0, 0, 2'd0, 0, 1);
    tbl[6]  = makeVec(1, 1, 0, 0, 2'd1, 1, 0);
    for (int i = 7; i <= 10; i++) tbl[i] = makeVec(1, 1, 0, 0, 2'd1, 0, 0);
    tbl[11] = makeVec(1, 0, 0, 0, 2'd1, 0, 0);
    tbl[12] = makeVec(1, 0, 0, 0, 2'd1, 0, 0);
    tbl[13] = makeVec(1, 0, 0, 0, 2'd1, 0, 1);
    tbl[14] = makeVec(1, 0, 0, 0, 2'd1, 0, 1);
    tbl[15] = makeVec(1, 0, 0, 0, 2'd1, 0, 1);
    tbl[16] = makeVec(1, 0, 0, 0, 2'd1, 0, 0);
    tbl[17] = makeVec(1, 0, 0, 0, 2'd1, 0, 0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].rstn, tbl[i].inc, tbl[i].dec, tbl[i].clr);
      checkOutput($sformatf("tbl%0d_valor_wrap", i), valor0, tbl[i].expValor);
      checkOutput($sformatf("tbl%0d_valor_sat", i), valor1, tbl[i].expValor);
      checkOutput($sformatf("tbl%0d_cambio", i), cambio0, tbl[i].expCambio);
      checkOutput($sformatf("tbl%0d_ocupado", i), ocup0, tbl[i].expOcup);
    end

    // Four clean presses from reset: wrapping vs saturating.
    exp0 = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp1 = '{2'd1, 2'd2, 2'd3, 2'd3};
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pulses0 = 0; pulses1 = 0;
    for (int p = 0; p < 4; p++) begin
      pressBtn(1'b1, 1'b0, 7, 7);
      checkOutput($sformatf("four_press%0d_wrap", p), valor0, exp0[p]);
      checkOutput($sformatf("four_press%0d_sat", p), valor1, exp1[p]);
    end
    checkOutput("four_press_pulses_wrap", pulses0, 4);
    checkOutput("four_press_pulses_sat", pulses1, 3);

    // Bouncing inc: one accepted press, timed from the start of the steady level.
    pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    base0 = valor0;
    pulses1 = 0;
    for (int t = 1; t <= 14; t++) begin
      applyStimulus(1'b1, (t <= 4) ? pat[t-1] : 1'b1, 1'b0, 1'b0);
      if (t == 9) checkOutput("bounce_before_accept", valor0, base0);
      if (t == 10) begin
        checkOutput("bounce_accept_valor", valor0, 2'(base0 + 2'd1));
        checkOutput("bounce_accept_cambio", cambio0, 1);
      end
    end
    pressBtn(1'b0, 1'b0, 0, 7);
    checkOutput("bounce_single_increment", valor0, 2'(base0 + 2'd1));
    checkOutput("saturated_press_no_pulse", pulses1, 0);

    // Both buttons together cancel; ocupado spans the confirmation window.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pulses0 = 0; pulses1 = 0; ocupCount = 0;
    for (int t = 0; t < 10; t++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("both_ocupado_cycles", ocupCount, 3);
    pressBtn(1'b0, 1'b0, 0, 8);
    checkOutput("both_valor", valor0, 0);
    checkOutput("both_pulses", pulses0 + pulses1, 0);

    // limpiar on the acceptance edge wins over the press.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pressBtn(1'b1, 1'b0, 7, 7);
    pressBtn(1'b1, 1'b0, 7, 7);
    checkOutput("clear_setup", valor0, 2);
    for (int t = 1; t <= 5; t++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("clear_valor", valor0, 0);
    checkOutput("clear_cambio", cambio0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("clear_cambio_one_cycle", cambio0, 0);
    pressBtn(1'b0, 1'b0, 0, 7);

    // Reset while dec is confirming; the still-held button is re-debounced once.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) pressBtn(1'b1, 1'b0, 7, 7);
    checkOutput("rst_setup", valor0, 3);
    for (int t = 1; t <= 3; t++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_confirming", ocup0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_valor", valor0, 0);
    checkOutput("rst_ocupado", ocup0, 0);
    for (int j = 1; j <= 12; j++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      if (j == 5) checkOutput("rst_redebounce_early", valor0, 0);
      if (j == 6) begin
        checkOutput("rst_redebounce_valor", valor0, 3);
        checkOutput("rst_redebounce_cambio", cambio0, 1);
        checkOutput("rst_redebounce_sat", valor1, 0);
      end
    end
    checkOutput("rst_no_autorepeat", valor0, 3);
    pressBtn(1'b0, 1'b0, 0, 7);

    // Randomized held levels with occasional clears and resets.
    holdInc = 0; holdDec = 0; lvlInc = 0; lvlDec = 0;
    for (int n = 0; n < 600; n++) begin
      if (holdInc == 0) begin
        lvlInc  = 1'($urandom_range(0, 1));
        holdInc = int'($urandom_range(1, 9));
      end
      if (holdDec == 0) begin
        lvlDec  = 1'($urandom_range(0, 1));
        holdDec = int'($urandom_range(1, 9));
      end
      holdInc--;
      holdDec--;
      applyStimulus(($urandom_range(0, 99) != 0), lvlInc, lvlDec, ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/acumulador_pulsos.md
ACUMULADOR_PULSOS -- requirements
Module: acumulador_pulsos

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a level change on a button (legal range 2..65535).
REQ-002 Parameter SATURAR, default 0: 0 = valor wraps modulo 4; 1 = valor saturates at 0 and 3.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 boton_inc  input  1  raw asynchronous push-button, active-high, increment request.
REQ-006 boton_dec  input  1  raw asynchronous push-button, active-high, decrement request.
REQ-007 limpiar  input  1  synchronous clear request, already clean, active-high.
REQ-008 valor  output  2  accumulated state C_D, registered, drives downstream LED decoder.
REQ-009 cambio  output  1  one-cycle pulse, high on the cycle after valor was updated.
REQ-010 ocupado  output  1  high while either button is in a CONFIRMA_* state.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer; its second-flop output is the sampled level s.
REQ-012 Each button SHALL have an independent debounce FSM: ESPERA (stable low), CONFIRMA_ALTO, ACTIVO (stable high), CONFIRMA_BAJO.
REQ-013 ESPERA -> CONFIRMA_ALTO when s=1; counter loads 1.
REQ-014 CONFIRMA_ALTO: s=1 increments counter; counter reaching DEBOUNCE_CYCLES -> ACTIVO and emits accepted press; s=0 -> ESPERA, counter cleared.
REQ-015 ACTIVO -> CONFIRMA_BAJO when s=0; CONFIRMA_BAJO returns to ACTIVO on s=1, to ESPERA after DEBOUNCE_CYCLES consecutive s=0; release emits nothing.
REQ-016 Debounce counters SHALL be 16 bits and never wrap; counter is zero in ESPERA and ACTIVO.
REQ-017 Accepted inc press SHALL update valor on the same clock edge the FSM enters ACTIVO: valor+1 (mod 4, or hold at 3 if SATURAR=1).
REQ-018 Accepted dec press: valor-1 (mod 4, or hold at 0 if SATURAR=1).
REQ-019 Inc and dec accepted on the same edge SHALL cancel: valor unchanged, cambio stays 0.
REQ-020 limpiar=1 SHALL force valor to 2'b00 on that edge, overriding any accepted press; debounce FSMs unaffected; cambio pulses only if valor was non-zero.
REQ-021 Saturated press (no value change) SHALL NOT pulse cambio.
REQ-022 cambio SHALL be high for exactly one cycle following each edge where valor changed.
REQ-023 Latency: raw button rising first sampled at edge k, held high, SHALL change valor at edge k+1+DEBOUNCE_CYCLES.
REQ-024 Holding a button indefinitely SHALL produce exactly one accepted press; no auto-repeat.
REQ-025 ocupado SHALL be combinational OR of the two FSMs being in CONFIRMA_ALTO or CONFIRMA_BAJO.

Reset
REQ-026 rst_n=0 at a clock edge SHALL set valor=2'b00, cambio=0, both FSMs to ESPERA, counters and synchronizer flops to 0, regardless of other inputs.
REQ-027 Reset mid-debounce SHALL discard the pending press; a button still held after reset SHALL be re-debounced from ESPERA and accepted once.
REQ-028 No state changes while rst_n=0; outputs hold reset values until the first edge with rst_n=1.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-029 Press boton_inc held 10 cycles, first sampled at edge k -> valor 00->01 at edge k+5, cambio=1 for one cycle, no further change.
REQ-030 Four clean inc presses from reset, SATURAR=0 -> valor 01,10,11,00 with four cambio pulses; SATURAR=1 -> 01,10,11,11 with three pulses.
REQ-031 Bounce: boton_inc toggles 1,0,1,0 each cycle then steady 1 -> exactly one increment, timed from start of steady 1 plus 2 sync cycles.
REQ-032 boton_inc and boton_dec rising on the same edge, both held -> valor unchanged, cambio never pulses, ocupado high for 3 cycles.
REQ-033 valor=10, limpiar asserted on the edge an inc press is accepted -> valor=00, one cambio pulse.
REQ-034 rst_n low for 1 cycle while boton_dec in CONFIRMA_ALTO (valor=11) -> valor=00, then held button decrements once to 11 (SATURAR=0) after 2+4 cycles.
